// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the single-port SPI RAM.
// Deserialises 10-bit MOSI frames {cmd[1:0], payload[7:0]} into rx_data with
// a one-cycle rx_valid strobe, and for read-data frames serialises the RAM's
// returned byte on MISO, MSB first. Everything runs on the SPI clock.
module spi_slave_ctrl #(
  parameter int unsigned FRAME_W = 10,
  parameter int unsigned DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  // Receive counter counts frame bits taken so far (0..FRAME_W).
  localparam int unsigned BCW = $clog2(FRAME_W + 1);
  // Transmit counter: 0 idle, 1..DATA_W bits driven, DATA_W+1 byte finished.
  localparam int unsigned TCW = $clog2(DATA_W + 2);

  localparam logic [BCW-1:0] FRAME_LAST = BCW'(FRAME_W - 1);
  localparam logic [BCW-1:0] FRAME_FULL = BCW'(FRAME_W);
  localparam logic [TCW-1:0] TX_FULL    = TCW'(DATA_W);
  localparam logic [TCW-1:0] TX_DONE    = TCW'(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t             state_q,        state_d;
  logic [BCW-1:0]     bit_cnt_q,      bit_cnt_d;
  logic [FRAME_W-1:0] shift_q,        shift_d;
  logic [FRAME_W-1:0] rx_data_q,      rx_data_d;
  logic               rx_valid_q,     rx_valid_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic               tx_loaded_q,    tx_loaded_d;
  logic [TCW-1:0]     tx_cnt_q,       tx_cnt_d;
  logic [DATA_W-1:0]  tx_shift_q,     tx_shift_d;
  logic               miso_q,         miso_d;

  logic               frame_done;
  logic [FRAME_W-1:0] frame_next;

  assign frame_done = (bit_cnt_q == FRAME_FULL);
  assign frame_next = {shift_q[FRAME_W-2:0], MOSI};

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_loaded_q    <= 1'b0;
      tx_cnt_q       <= '0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_loaded_q    <= tx_loaded_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_shift_q     <= tx_shift_d;
      miso_q         <= miso_d;
    end
  end

  // Next-state logic: frame reception, command routing and read-back shifting.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_loaded_d    = tx_loaded_q;
    tx_cnt_d       = tx_cnt_q;
    tx_shift_d     = tx_shift_q;
    miso_d         = miso_q;

    if (state_q != IDLE && SS_n) begin
      // Deselect aborts whatever is in flight; a partial frame is dropped.
      state_d     = IDLE;
      bit_cnt_d   = '0;
      tx_cnt_d    = '0;
      tx_loaded_d = 1'b0;
      miso_d      = 1'b0;
      if (tx_cnt_q == TX_FULL) begin
        // Last data bit was already on the wire: the byte counts as sent.
        rd_addr_seen_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!SS_n) begin
            state_d = CHK_CMD;
          end
        end

        CHK_CMD: begin
          // First frame bit is cmd[1]; it alone selects the path.
          shift_d   = FRAME_W'(MOSI);
          bit_cnt_d = BCW'(1);
          if (!MOSI) begin
            state_d = WRITE;
          end else if (rd_addr_seen_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done) begin
            shift_d   = frame_next;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == FRAME_LAST) begin
              rx_data_d  = frame_next;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) begin
                rd_addr_seen_d = 1'b1;
              end
            end
          end

          if (state_q == READ_DATA && frame_done) begin
            if (!tx_loaded_q) begin
              // MSB goes out on the same edge that sees tx_valid.
              if (tx_valid) begin
                miso_d      = tx_data[DATA_W-1];
                tx_shift_d  = {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt_d    = TCW'(1);
                tx_loaded_d = 1'b1;
              end
            end else if (tx_cnt_q < TX_FULL) begin
              miso_d     = tx_shift_q[DATA_W-1];
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
              tx_cnt_d   = tx_cnt_q + TCW'(1);
            end else if (tx_cnt_q == TX_FULL) begin
              miso_d         = 1'b0;
              rd_addr_seen_d = 1'b0;
              tx_cnt_d       = TX_DONE;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: directed scenarios followed by
// random transactions, checked against a transaction-level model that tracks
// only whether a read address is pending and which frames/bytes must appear.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_cmp;
  int n_err;
  int exp_pulses;
  int got_pulses;
  bit m_seen;

  spi_slave_ctrl #(
    .FRAME_W (10),
    .DATA_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every rx_valid cycle independently of the scenario checks.
  always @(negedge clk) begin
    if (rx_valid) got_pulses = got_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SS_n-low transaction. Starts and ends at a negedge with the DUT idle.
  // nbits < 10 aborts the frame by raising SS_n after that many bits.
  task automatic do_frame(input logic [9:0] f, input int nbits,
                          input bit tx_pre, input logic [7:0] b);
    int  d;
    bit  is_rd;
    if (tx_pre) begin
      tx_data  = b;
      tx_valid = 1'b1;
    end
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    @(negedge clk);
    chk("cmd_rxv", 32'(rx_valid), 32'd0);
    for (int k = 0; k < nbits; k++) begin
      MOSI = f[9-k];
      @(negedge clk);
      chk("bit_rxv", 32'(rx_valid), (k == 9) ? 32'd1 : 32'd0);
      chk("bit_miso", 32'(MISO), 32'd0);
    end
    if (nbits < 10) begin
      SS_n = 1'b1;
      @(negedge clk);
      chk("abort_rxv", 32'(rx_valid), 32'd0);
      chk("abort_miso", 32'(MISO), 32'd0);
      tx_valid = 1'b0;
      return;
    end
    chk("rx_data", 32'(rx_data), 32'(f));
    exp_pulses = exp_pulses + 1;
    is_rd = f[9] && m_seen;
    if (f[9] && !m_seen) m_seen = 1'b1;
    if (is_rd) begin
      d = tx_pre ? 0 : int'($urandom_range(0, 3));
      for (int i = 0; i < d; i++) begin
        MOSI = 1'($urandom);
        @(negedge clk);
        chk("wait_miso", 32'(MISO), 32'd0);
        chk("wait_rxv", 32'(rx_valid), 32'd0);
      end
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        MOSI = 1'($urandom);
        @(negedge clk);
        chk("miso_bit", 32'(MISO), 32'(b[i]));
      end
      @(negedge clk);
      chk("miso_end", 32'(MISO), 32'd0);
      m_seen = 1'b0;
      for (int i = 0; i < (tx_pre ? 20 : 2); i++) begin
        @(negedge clk);
        chk("miso_once", 32'(MISO), 32'd0);
      end
      tx_valid = 1'b0;
    end else begin
      d = int'($urandom_range(0, 3));
      for (int i = 0; i < d; i++) begin
        MOSI     = 1'($urandom);
        tx_data  = 8'($urandom);
        tx_valid = 1'($urandom);
        @(negedge clk);
        chk("tail_rxv", 32'(rx_valid), 32'd0);
        chk("tail_miso", 32'(MISO), 32'd0);
      end
      tx_valid = 1'b0;
    end
    SS_n = 1'b1;
    @(negedge clk);
    chk("end_rxv", 32'(rx_valid), 32'd0);
    chk("end_miso", 32'(MISO), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] f;
    logic [7:0] b;
    int nb;
    n_cmp = 0; n_err = 0; exp_pulses = 0; got_pulses = 0; m_seen = 1'b0;
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    #3;
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_rxdata", 32'(rx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write address, write data.
    do_frame(10'h05A, 10, 1'b0, 8'h00);
    do_frame(10'h1C3, 10, 1'b0, 8'h00);
    // Read address then read data returning 0xC3.
    do_frame(10'h25A, 10, 1'b0, 8'h00);
    do_frame(10'h3E7, 10, 1'b0, 8'hC3);
    // Read-data command with no pending address is treated as an address.
    do_frame(10'h3AA, 10, 1'b1, 8'hFF);
    do_frame(10'h311, 10, 1'b0, 8'h96);
    // Aborted frame after 6 bits, then a full frame.
    do_frame(10'h2F0, 6, 1'b0, 8'h00);
    do_frame(10'h0A5, 10, 1'b0, 8'h00);

    // Async reset in the middle of shifting a read byte out.
    do_frame(10'h201, 10, 1'b0, 8'h00);
    SS_n = 1'b0;
    @(negedge clk);
    f = 10'h3C0;
    for (int k = 0; k < 10; k++) begin
      MOSI = f[9-k];
      @(negedge clk);
    end
    chk("rd_rxv", 32'(rx_valid), 32'd1);
    exp_pulses = exp_pulses + 1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk); chk("pre_rst_b7", 32'(MISO), 32'd1);
    @(negedge clk); chk("pre_rst_b6", 32'(MISO), 32'd0);
    @(negedge clk); chk("pre_rst_b5", 32'(MISO), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_miso", 32'(MISO), 32'd0);
    chk("rst_mid_rxv", 32'(rx_valid), 32'd0);
    m_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
    @(negedge clk);
    // Pending address was cleared: this goes to address path, no MISO.
    do_frame(10'h3FF, 10, 1'b1, 8'hFF);
    // tx_valid held high throughout: byte must go out exactly once.
    do_frame(10'h3C3, 10, 1'b1, 8'h5C);

    // Random transactions.
    for (int t = 0; t < 40; t++) begin
      f  = 10'($urandom);
      b  = 8'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 10;
      do_frame(f, nb, 1'($urandom), b);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(negedge clk);
        chk("gap_rxv", 32'(rx_valid), 32'd0);
      end
    end

    chk("pulse_count", 32'(got_pulses), 32'(exp_pulses));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
